// File: rtl/apb_master.sv
// APB3 requester: accepts single read/write commands on a valid/ready port,
// runs the IDLE -> SETUP -> ACCESS bus sequence with PREADY wait states, and
// reports completion (read data or timeout) on a one-cycle response pulse.
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PENABLE,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  // Counter wide enough to hold TIMEOUT_CYCLES; one spare bit for the compare.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W:0] TIMEOUT_LIM = TIMEOUT_CYCLES[CNT_W:0];
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   wait_next;
  logic             timeout_hit;

  // Wait count after this stalled ACCESS cycle, and whether it hits the abort limit.
  always_comb begin
    wait_next   = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};
    timeout_hit = TIMEOUT_EN && (wait_next == TIMEOUT_LIM);
  end

  // Bus sequencer: every APB and response output is a register updated here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PSELx       <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PENABLE     <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state     <= ST_SETUP;
            cmd_ready <= 1'b0;
            PSELx     <= 1'b1;
            PADDR     <= cmd_addr;
            PWRITE    <= cmd_write;
            PWDATA    <= cmd_write ? cmd_wdata : '0;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (PREADY || timeout_hit) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_timeout <= !PREADY;
            rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWDATA      <= '0;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_next[CNT_W-1:0];
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          PSELx     <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: the bench plays the APB slave and compares
// every cycle of each transfer against a phase-based model of the bus sequence.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 16;

  logic          PCLK      = 1'b0;
  logic          PRESET    = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSELx;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PENABLE;
  logic          PREADY    = 1'b0;
  logic [DW-1:0] PRDATA    = '0;

  apb_master #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSELx      (PSELx),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PENABLE    (PENABLE),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA)
  );

  // Free-running bus clock, 10 time units per period.
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic          psel;
    logic          pen;
    logic          pwrite;
    logic          cmd_ready;
    logic          rsp_valid;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] rsp_rdata;
  } snap_t;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] last_rsp = '0;
  logic          accept_ready;
  snap_t         trace [1:40];
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic snap_t sample();
    snap_t s;
    s.psel        = PSELx;
    s.pen         = PENABLE;
    s.pwrite      = PWRITE;
    s.cmd_ready   = cmd_ready;
    s.rsp_valid   = rsp_valid;
    s.rsp_timeout = rsp_timeout;
    s.paddr       = PADDR;
    s.pwdata      = PWDATA;
    s.rsp_rdata   = rsp_rdata;
    return s;
  endfunction

  // Reference: cycle k after acceptance is SETUP (k=1), ACCESS (2..resp_k-1),
  // response (resp_k) or plain idle afterwards.
  function automatic snap_t expect_cycle(input int k, input int resp_k, input logic wr,
                                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                         input logic [DW-1:0] rsp, input logic to,
                                         input logic [DW-1:0] prev_rsp);
    snap_t e;
    e.paddr       = addr;
    e.pwrite      = wr;
    e.psel        = (k < resp_k);
    e.pen         = (k >= 2) && (k < resp_k);
    e.pwdata      = ((k < resp_k) && wr) ? wdata : '0;
    e.cmd_ready   = (k >= resp_k);
    e.rsp_valid   = (k == resp_k);
    e.rsp_timeout = (k == resp_k) && to;
    e.rsp_rdata   = (k >= resp_k) ? rsp : prev_rsp;
    return e;
  endfunction

  // Issue one command and act as slave, recording cycles N+1 .. resp_k+1.
  task automatic drive_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input int waits, input logic [DW-1:0] rdata, input bit stall);
    int resp_k;
    resp_k = stall ? TO + 2 : waits + 3;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    PREADY    = 1'b0;
    PRDATA    = DW'($urandom);
    accept_ready = cmd_ready;
    @(posedge PCLK);
    for (int k = 1; k <= resp_k + 1; k++) begin
      @(negedge PCLK);
      cmd_valid = (k < resp_k) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      trace[k]  = sample();
      if (k >= 2) begin
        PREADY = !stall && ((k - 2) >= waits);
        PRDATA = PREADY ? rdata : DW'($urandom);
      end
    end
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
  endtask

  task automatic test_reset();
    snap_t s;
    snap_t rst_val;
    rst_val = '0;
    rst_val.cmd_ready = 1'b1;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    s = sample();
    checks++;
    if (s !== rst_val) begin
      failures++;
      $display("[TB] FAIL reset_state: got %h want %h", s, rst_val);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0123;
    PREADY    = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    s = sample();
    checks++;
    if ({s.psel, s.pen} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL reset_pre_access: got psel/pen %b%b want 11", s.psel, s.pen);
    end
    #2 PRESET = 1'b1;
    #1 s = sample();
    checks++;
    if (s !== rst_val) begin
      failures++;
      $display("[TB] FAIL reset_async: got %h want %h", s, rst_val);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      s = sample();
      checks++;
      if (s !== rst_val) begin
        failures++;
        $display("[TB] FAIL reset_after cycle %0d: got %h want %h", i, s, rst_val);
      end
    end
    last_rsp = '0;
  endtask

  task automatic test_write_zero_wait();
    snap_t e;
    drive_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    checks++;
    if (accept_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write0_ready: got %b want 1", accept_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      e = expect_cycle(k, 3, 1'b1, 16'h0010, 32'hDEADBEEF, '0, 1'b0, last_rsp);
      checks++;
      if (trace[k] !== e) begin
        failures++;
        $display("[TB] FAIL write0 cycle N+%0d: got %h want %h", k, trace[k], e);
      end
    end
    last_rsp = '0;
  endtask

  task automatic test_read_waits();
    snap_t e;
    drive_xfer(1'b0, 16'h0020, DW'($urandom), 3, 32'hCAFE0001, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      e = expect_cycle(k, 6, 1'b0, 16'h0020, '0, 32'hCAFE0001, 1'b0, last_rsp);
      checks++;
      if (trace[k] !== e) begin
        failures++;
        $display("[TB] FAIL read3 cycle N+%0d: got %h want %h", k, trace[k], e);
      end
    end
    last_rsp = 32'hCAFE0001;
  endtask

  task automatic test_stability();
    snap_t         e;
    logic [DW-1:0] d;
    d = DW'($urandom);
    drive_xfer(1'b1, 16'hA5A4, d, 5, DW'($urandom), 1'b0);
    for (int k = 1; k <= 9; k++) begin
      e = expect_cycle(k, 8, 1'b1, 16'hA5A4, d, '0, 1'b0, last_rsp);
      checks++;
      if (trace[k] !== e) begin
        failures++;
        $display("[TB] FAIL stable5 cycle N+%0d: got %h want %h", k, trace[k], e);
      end
    end
    last_rsp = '0;
  endtask

  task automatic test_timeout();
    snap_t e;
    drive_xfer(1'b0, 16'h0100, '0, 0, '0, 1'b1);
    for (int k = 1; k <= TO + 3; k++) begin
      e = expect_cycle(k, TO + 2, 1'b0, 16'h0100, '0, '0, 1'b1, last_rsp);
      checks++;
      if (trace[k] !== e) begin
        failures++;
        $display("[TB] FAIL timeout cycle N+%0d: got %h want %h", k, trace[k], e);
      end
    end
    last_rsp = '0;
  endtask

  task automatic test_back_to_back();
    snap_t         s;
    snap_t         e;
    logic [DW-1:0] d;
    d = DW'($urandom);
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0004;
    cmd_wdata = d;
    PREADY    = 1'b1;
    PRDATA    = '0;
    @(posedge PCLK);
    for (int k = 1; k <= 3; k++) begin
      @(negedge PCLK);
      cmd_valid = 1'b0;
      s = sample();
      e = expect_cycle(k, 3, 1'b1, 16'h0004, d, '0, 1'b0, last_rsp);
      checks++;
      if (s !== e) begin
        failures++;
        $display("[TB] FAIL b2b_write cycle N+%0d: got %h want %h", k, s, e);
      end
      if (s.psel && s.pen && s.pwrite) mem[s.paddr] = s.pwdata;
      if (k == 3) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0004;
        cmd_wdata = DW'($urandom);
      end
    end
    last_rsp = '0;
    @(posedge PCLK);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      cmd_valid = 1'b0;
      s = sample();
      e = expect_cycle(k, 3, 1'b0, 16'h0004, '0, d, 1'b0, last_rsp);
      checks++;
      if (s !== e) begin
        failures++;
        $display("[TB] FAIL b2b_read cycle M+%0d: got %h want %h", k, s, e);
      end
      if (k == 2) PRDATA = (mem.exists(s.paddr)) ? mem[s.paddr] : ~d;
    end
    last_rsp = d;
    PREADY   = 1'b0;
  endtask

  task automatic test_random();
    snap_t         e;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [DW-1:0] rsp;
    int            waits;
    for (int t = 0; t < 10; t++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = AW'(16'h0200 + 4 * $urandom_range(0, 3));
      wdata = DW'($urandom);
      waits = $urandom_range(0, 6);
      rdata = mem.exists(addr) ? mem[addr] : DW'($urandom);
      rsp   = wr ? '0 : rdata;
      drive_xfer(wr, addr, wdata, waits, rdata, 1'b0);
      checks++;
      if (accept_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL rand%0d_ready: got %b want 1", t, accept_ready);
      end
      for (int k = 1; k <= waits + 4; k++) begin
        e = expect_cycle(k, waits + 3, wr, addr, wdata, rsp, 1'b0, last_rsp);
        checks++;
        if (trace[k] !== e) begin
          failures++;
          $display("[TB] FAIL rand%0d cycle N+%0d: got %h want %h", t, k, trace[k], e);
        end
      end
      if (wr) mem[addr] = wdata;
      last_rsp = rsp;
    end
  endtask

  // Test sequence followed by the single summary line.
  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_stability();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
